safe_lock_controller: RTL and testbench

- Top-level sequencer for the digital safe.
- Walks the unlock flow: joystick stage, then arm wait, then pincode stage, then unlocked.
- Drives the stage resets, the servo angle and the display/keypad owner select from one registered state machine.
- Adds two features the flow lacks today: counting of failed attempts with a timed lockout, and per-stage inactivity timeouts.

---
 rtl/safe_lock_controller_if.sv | 31 +++
 rtl/safe_lock_controller.sv | 198 +++++++++++++++++++
 tb/tb_safe_lock_controller.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/safe_lock_controller_if.sv
// Bus between the safe sequencer and the rest of the safe: the stage
// pass/fail levels and the keypad events come in, the stage resets,
// servo angle, display owner select and status outputs go out.
interface safe_lock_controller_if;
    logic       joy_pass;
    logic       joy_fail;
    logic       pin_pass;
    logic       pin_fail;
    logic       key_press;
    logic [3:0] key_num;

    logic       joy_rst_n;
    logic       pin_rst_n;
    logic [7:0] angle;
    logic [1:0] disp_sel;
    logic [2:0] indicator;
    logic [3:0] fail_count;
    logic       locked_out;

    // Side that feeds the controller (stages, keypad, or a testbench)
    modport master (
        output joy_pass, joy_fail, pin_pass, pin_fail, key_press, key_num,
        input  joy_rst_n, pin_rst_n, angle, disp_sel, indicator, fail_count, locked_out
    );

    // The controller itself
    modport slave (
        input  joy_pass, joy_fail, pin_pass, pin_fail, key_press, key_num,
        output joy_rst_n, pin_rst_n, angle, disp_sel, indicator, fail_count, locked_out
    );
endinterface

// File: rtl/safe_lock_controller.sv
// Top-level sequencer of the digital safe. Walks joystick stage -> arm wait
// -> pincode stage -> open, with a consecutive-failure counter that leads to
// a timed lockout, and an inactivity timeout in the JOY, ARM and PIN states.
// Every output is registered from the next-state decode so it changes on the
// same edge as the state.
module safe_lock_controller #(
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 30000,
    parameter int STAGE_TIMEOUT  = 60000,
    parameter int OPEN_ANGLE     = 135
) (
    input  logic                   clk,
    input  logic                   reset,
    safe_lock_controller_if.slave  bus
);

    // One timer serves both the stage inactivity limit and the lockout
    // duration, so it is sized for whichever is longer.
    localparam int TIMER_MAX = (LOCKOUT_CYCLES > STAGE_TIMEOUT) ? LOCKOUT_CYCLES : STAGE_TIMEOUT;
    localparam int TW        = $clog2(TIMER_MAX + 1);

    localparam logic [TW-1:0] STAGE_LAST = TW'(STAGE_TIMEOUT - 1);
    localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_SAT  = {TW{1'b1}};
    localparam logic [3:0]    FAIL_LIMIT = 4'(MAX_FAILS);
    localparam logic [7:0]    OPEN_POS   = 8'(OPEN_ANGLE);
    localparam logic [3:0]    KEY_CANCEL = 4'hC;

    // S_CANCEL is the one-cycle joystick reset pulse used when leaving ARM
    // without it counting as a failure.
    typedef enum logic [2:0] {
        S_JOY,
        S_ARM,
        S_PIN,
        S_FAIL,
        S_CANCEL,
        S_LOCKOUT,
        S_OPEN
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] timer;
    logic [TW-1:0] next_timer;
    logic [3:0]    fail_cnt;
    logic [3:0]    next_fail_cnt;

    logic          joy_rst_n_q,  joy_rst_n_d;
    logic          pin_rst_n_q,  pin_rst_n_d;
    logic [7:0]    angle_q,      angle_d;
    logic [1:0]    disp_sel_q,   disp_sel_d;
    logic [2:0]    indicator_q,  indicator_d;
    logic          locked_out_q, locked_out_d;

    logic          key_clears;
    logic          stage_timeout;
    logic          cancel_key;

    assign cancel_key    = (bus.key_num == KEY_CANCEL);
    assign key_clears    = bus.key_press && ((state == S_JOY) || (state == S_PIN));
    assign stage_timeout = (timer >= STAGE_LAST) && !key_clears;

    // Next-state decode: fail beats pass, pass/fail beat timeout, timeout beats keys
    always_comb begin
        next_state = state;
        case (state)
            S_JOY: begin
                if (bus.joy_fail)
                    next_state = S_FAIL;
                else if (bus.joy_pass)
                    next_state = S_ARM;
                else if (stage_timeout)
                    next_state = S_FAIL;
            end
            S_ARM: begin
                if (stage_timeout)
                    next_state = S_CANCEL;
                else if (bus.key_press)
                    next_state = cancel_key ? S_CANCEL : S_PIN;
            end
            S_PIN: begin
                if (bus.pin_fail)
                    next_state = S_FAIL;
                else if (bus.pin_pass)
                    next_state = S_OPEN;
                else if (stage_timeout)
                    next_state = S_FAIL;
            end
            S_FAIL:
                next_state = (fail_cnt >= FAIL_LIMIT) ? S_LOCKOUT : S_JOY;
            S_CANCEL:
                next_state = S_JOY;
            S_LOCKOUT: begin
                if (timer >= LOCK_LAST)
                    next_state = S_JOY;
            end
            S_OPEN: begin
                if (bus.key_press && !cancel_key)
                    next_state = S_JOY;
            end
            default:
                next_state = S_JOY;
        endcase
    end

    // Timer restarts on every state entry and on keypad activity in JOY/PIN, else saturates upward
    always_comb begin
        next_timer = timer;
        if ((next_state != state) || key_clears)
            next_timer = '0;
        else if (timer != TIMER_SAT)
            next_timer = timer + TW'(1);
    end

    // Failure count bumps on FAIL entry (so FAIL already sees the new value), clears on OPEN entry and lockout exit
    always_comb begin
        next_fail_cnt = fail_cnt;
        if ((next_state == S_FAIL) && (state != S_FAIL))
            next_fail_cnt = (fail_cnt == 4'd15) ? 4'd15 : fail_cnt + 4'd1;
        else if ((next_state == S_OPEN) && (state != S_OPEN))
            next_fail_cnt = 4'd0;
        else if ((state == S_LOCKOUT) && (next_state == S_JOY))
            next_fail_cnt = 4'd0;
    end

    // Output decode from the state being entered
    always_comb begin
        joy_rst_n_d  = 1'b0;
        pin_rst_n_d  = 1'b0;
        angle_d      = 8'd0;
        disp_sel_d   = 2'b00;
        indicator_d  = 3'b100;
        locked_out_d = 1'b0;
        case (next_state)
            S_JOY: begin
                joy_rst_n_d = 1'b1;
            end
            S_ARM: begin
                joy_rst_n_d = 1'b1;
                disp_sel_d  = 2'b10;
                indicator_d = 3'b101;
            end
            S_PIN: begin
                pin_rst_n_d = 1'b1;
                disp_sel_d  = 2'b01;
                indicator_d = 3'b101;
            end
            S_LOCKOUT: begin
                disp_sel_d   = 2'b10;
                indicator_d  = 3'b111;
                locked_out_d = 1'b1;
            end
            S_OPEN: begin
                pin_rst_n_d = 1'b1;
                angle_d     = OPEN_POS;
                disp_sel_d  = 2'b10;
                indicator_d = 3'b011;
            end
            default: begin
                joy_rst_n_d = 1'b0;
            end
        endcase
    end

    // State, timer, failure count and registered outputs; reset drops the servo to 0 (locked) at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_JOY;
            timer        <= '0;
            fail_cnt     <= 4'd0;
            joy_rst_n_q  <= 1'b0;
            pin_rst_n_q  <= 1'b0;
            angle_q      <= 8'd0;
            disp_sel_q   <= 2'b00;
            indicator_q  <= 3'b100;
            locked_out_q <= 1'b0;
        end else begin
            state        <= next_state;
            timer        <= next_timer;
            fail_cnt     <= next_fail_cnt;
            joy_rst_n_q  <= joy_rst_n_d;
            pin_rst_n_q  <= pin_rst_n_d;
            angle_q      <= angle_d;
            disp_sel_q   <= disp_sel_d;
            indicator_q  <= indicator_d;
            locked_out_q <= locked_out_d;
        end
    end

    assign bus.joy_rst_n  = joy_rst_n_q;
    assign bus.pin_rst_n  = pin_rst_n_q;
    assign bus.angle      = angle_q;
    assign bus.disp_sel   = disp_sel_q;
    assign bus.indicator  = indicator_q;
    assign bus.fail_count = fail_cnt;
    assign bus.locked_out = locked_out_q;

endmodule

// File: tb/tb_safe_lock_controller.sv
// Testbench for safe_lock_controller: directed walks through the unlock,
// lockout, cancel, timeout and reset situations, then a long randomized run.
// A behavioural model of the safe (stage name plus countdowns) predicts every
// output after every clock edge.
module tb_safe_lock_controller;

    localparam int MAX_FAILS      = 3;
    localparam int LOCKOUT_CYCLES = 20;
    localparam int STAGE_TIMEOUT  = 50;
    localparam int OPEN_ANGLE     = 135;

    localparam int M_JOY    = 0;
    localparam int M_ARM    = 1;
    localparam int M_PIN    = 2;
    localparam int M_FAIL   = 3;
    localparam int M_CANCEL = 4;
    localparam int M_LOCK   = 5;
    localparam int M_OPEN   = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    int m_mode;
    int m_fails;
    int m_idle_left;
    int m_lock_left;
    bit m_fresh;

    int run_len;
    bit run_done;

    safe_lock_controller_if bus ();

    safe_lock_controller #(
        .MAX_FAILS      (MAX_FAILS),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .STAGE_TIMEOUT  (STAGE_TIMEOUT),
        .OPEN_ANGLE     (OPEN_ANGLE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode      = M_JOY;
        m_fails     = 0;
        m_idle_left = STAGE_TIMEOUT;
        m_lock_left = 0;
        m_fresh     = 1'b1;
    endfunction

    function automatic void model_enter(input int next_mode);
        m_mode      = next_mode;
        m_idle_left = STAGE_TIMEOUT;
        if (next_mode == M_LOCK)
            m_lock_left = LOCKOUT_CYCLES;
        if (next_mode == M_FAIL)
            m_fails = (m_fails < 15) ? m_fails + 1 : 15;
        if (next_mode == M_OPEN)
            m_fails = 0;
    endfunction

    function automatic void model_step(input logic jp, input logic jf, input logic pp,
                                       input logic pf, input logic kp, input logic [3:0] kn);
        bit idle_expired;
        idle_expired = 1'b0;
        m_fresh      = 1'b0;
        if ((m_mode == M_JOY || m_mode == M_PIN) && kp)
            m_idle_left = STAGE_TIMEOUT;
        else if (m_mode == M_JOY || m_mode == M_ARM || m_mode == M_PIN) begin
            if (m_idle_left == 1)
                idle_expired = 1'b1;
            else
                m_idle_left--;
        end
        case (m_mode)
            M_JOY: begin
                if (jf)                model_enter(M_FAIL);
                else if (jp)           model_enter(M_ARM);
                else if (idle_expired) model_enter(M_FAIL);
            end
            M_ARM: begin
                if (idle_expired) model_enter(M_CANCEL);
                else if (kp)      model_enter((kn == 4'hC) ? M_CANCEL : M_PIN);
            end
            M_PIN: begin
                if (pf)                model_enter(M_FAIL);
                else if (pp)           model_enter(M_OPEN);
                else if (idle_expired) model_enter(M_FAIL);
            end
            M_FAIL:   model_enter((m_fails >= MAX_FAILS) ? M_LOCK : M_JOY);
            M_CANCEL: model_enter(M_JOY);
            M_LOCK: begin
                m_lock_left--;
                if (m_lock_left == 0) begin
                    m_fails = 0;
                    model_enter(M_JOY);
                end
            end
            M_OPEN: begin
                if (kp && kn != 4'hC) model_enter(M_JOY);
            end
            default: model_enter(M_JOY);
        endcase
    endfunction

    task automatic check_all();
        logic       e_joy, e_pin, e_lock;
        logic [7:0] e_angle;
        logic [1:0] e_disp;
        logic [2:0] e_ind;
        e_joy = 1'b0; e_pin = 1'b0; e_lock = 1'b0;
        e_angle = 8'd0; e_disp = 2'b00; e_ind = 3'b100;
        if (!m_fresh) begin
            case (m_mode)
                M_JOY:  e_joy = 1'b1;
                M_ARM:  begin e_joy = 1'b1; e_disp = 2'b10; e_ind = 3'b101; end
                M_PIN:  begin e_pin = 1'b1; e_disp = 2'b01; e_ind = 3'b101; end
                M_LOCK: begin e_disp = 2'b10; e_ind = 3'b111; e_lock = 1'b1; end
                M_OPEN: begin e_pin = 1'b1; e_angle = 8'(OPEN_ANGLE); e_disp = 2'b10; e_ind = 3'b011; end
                default: ;
            endcase
        end
        checkOutput("joy_rst_n",  32'(bus.joy_rst_n),  32'(e_joy));
        checkOutput("pin_rst_n",  32'(bus.pin_rst_n),  32'(e_pin));
        checkOutput("angle",      32'(bus.angle),      32'(e_angle));
        checkOutput("disp_sel",   32'(bus.disp_sel),   32'(e_disp));
        checkOutput("indicator",  32'(bus.indicator),  32'(e_ind));
        checkOutput("fail_count", 32'(bus.fail_count), 32'(m_fails));
        checkOutput("locked_out", 32'(bus.locked_out), 32'(e_lock));
    endtask

    task automatic applyStimulus(input logic jp, input logic jf, input logic pp,
                                 input logic pf, input logic kp, input logic [3:0] kn);
        bus.joy_pass  = jp;
        bus.joy_fail  = jf;
        bus.pin_pass  = pp;
        bus.pin_fail  = pf;
        bus.key_press = kp;
        bus.key_num   = kn;
        @(posedge clk);
        model_step(jp, jf, pp, pf, kp, kn);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic key(input logic [3:0] kn);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, kn);
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.joy_pass = 1'b0; bus.joy_fail = 1'b0;
        bus.pin_pass = 1'b0; bus.pin_fail = 1'b0;
        bus.key_press = 1'b0; bus.key_num = 4'h0;
        model_reset();
        @(negedge clk);
        doReset();

        // Happy path: JOY -> ARM -> PIN -> OPEN -> JOY
        idle(1);
        checkOutput("rel_joy_rst", 32'(bus.joy_rst_n), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("hp_arm_ind", 32'(bus.indicator), 32'd5);
        key(4'h5);
        checkOutput("hp_pin_ind", 32'(bus.indicator), 32'd5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("hp_open_ind", 32'(bus.indicator), 32'd3);
        checkOutput("hp_open_angle", 32'(bus.angle), 32'd135);
        key(4'h1);
        checkOutput("hp_back_ind", 32'(bus.indicator), 32'd4);
        checkOutput("hp_back_angle", 32'(bus.angle), 32'd0);
        checkOutput("hp_fail_count", 32'(bus.fail_count), 32'd0);

        // Three joystick failures lead to a lockout of exactly LOCKOUT_CYCLES
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("fail_1", 32'(bus.fail_count), 32'd1);
        idle(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("fail_2", 32'(bus.fail_count), 32'd2);
        idle(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("fail_3", 32'(bus.fail_count), 32'd3);
        run_len = 0;
        run_done = 1'b0;
        for (int i = 0; i < 60 && !run_done; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5);
            if (bus.locked_out)
                run_len++;
            else if (run_len > 0)
                run_done = 1'b1;
        end
        checkOutput("lock_len", 32'(run_len), 32'(LOCKOUT_CYCLES));
        checkOutput("lock_exit_count", 32'(bus.fail_count), 32'd0);
        checkOutput("lock_exit_joy", 32'(bus.joy_rst_n), 32'd1);

        // Cancel in ARM pulses the joystick reset without counting a failure
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        key(4'hC);
        checkOutput("cancel_pulse", 32'(bus.joy_rst_n), 32'd0);
        idle(1);
        checkOutput("cancel_joy", 32'(bus.joy_rst_n), 32'd1);
        checkOutput("cancel_count", 32'(bus.fail_count), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        key(4'h5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        key(4'hC);
        checkOutput("open_cancel_angle", 32'(bus.angle), 32'd135);
        key(4'h1);

        // PIN inactivity timeout, plain and restarted by a key press at cycle 30
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        key(4'h5);
        run_len = 0;
        for (int i = 1; i <= 100 && run_len == 0; i++) begin
            idle(1);
            if (!bus.pin_rst_n) run_len = i;
        end
        checkOutput("pin_timeout_len", 32'(run_len), 32'(STAGE_TIMEOUT));
        checkOutput("pin_timeout_count", 32'(bus.fail_count), 32'd1);
        idle(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        key(4'h5);
        run_len = 0;
        for (int i = 1; i <= 150 && run_len == 0; i++) begin
            if (i == 30) key(4'h7);
            else         idle(1);
            if (!bus.pin_rst_n) run_len = i;
        end
        checkOutput("pin_restart_len", 32'(run_len), 32'd80);
        checkOutput("pin_restart_count", 32'(bus.fail_count), 32'd2);
        idle(1);

        // Simultaneous pass and fail, and a stray pin_pass in JOY
        doReset();
        idle(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("both_is_fail", 32'(bus.joy_rst_n), 32'd0);
        checkOutput("both_count", 32'(bus.fail_count), 32'd1);
        idle(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("stray_pin_pass", 32'(bus.indicator), 32'd4);

        // Asynchronous reset while open locks the safe before the next edge
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        key(4'h5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("pre_reset_angle", 32'(bus.angle), 32'd135);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_angle", 32'(bus.angle), 32'd0);
        checkOutput("async_joy_rst", 32'(bus.joy_rst_n), 32'd0);
        checkOutput("async_ind", 32'(bus.indicator), 32'd4);
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Randomized run with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0)
                doReset();
            else
                applyStimulus(($urandom_range(0, 5) == 0),
                              ($urandom_range(0, 11) == 0),
                              ($urandom_range(0, 5) == 0),
                              ($urandom_range(0, 11) == 0),
                              ($urandom_range(0, 3) == 0),
                              ($urandom_range(0, 3) == 0) ? 4'hC : 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
